// File: rtl/z80_bus_arbiter.sv
// Arbitrates the 8 KB Z80 work RAM between the 68k and the Z80, and holds the
// 68k-visible Z80 BUSREQ / RESET control registers.
module z80_bus_arbiter #(
  parameter int          RAM_AW      = 13,
  parameter logic [23:0] BUSREQ_ADDR = 24'hA11100,
  parameter logic [23:0] RESET_ADDR  = 24'hA11200,
  parameter logic [23:0] RAM_BASE    = 24'hA00000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [23:0]       m68_addr,
  input  logic [15:0]       m68_wdata,
  output logic [15:0]       m68_rdata,
  input  logic              m68_as_n,
  input  logic              m68_uds_n,
  input  logic              m68_lds_n,
  input  logic              m68_rw,
  output logic              m68_dtack_n,
  input  logic [15:0]       z80_addr,
  input  logic [7:0]        z80_wdata,
  output logic [7:0]        z80_rdata,
  input  logic              z80_mreq_n,
  input  logic              z80_rd_n,
  input  logic              z80_wr_n,
  input  logic              z80_busack_n,
  output logic              z80_busrq_n,
  output logic              z80_reset_n,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic [1:0]        dbg_state_o,
  output logic              dbg_grant_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RDWAIT = 2'd1,
    S_ACK    = 2'd2
  } state_e;

  localparam logic [16:0] RAM_SIZE = 17'(1 << RAM_AW);

  state_e      state_q, state_d;
  logic        busreq_q, busreq_d;
  logic        zreset_q, zreset_d;
  logic        grant_q;
  logic [15:0] rdata_q, rdata_d;
  logic        m68_ram_we;

  logic              hit_busreq, hit_reset, hit_ram, m68_sel, a0, z80_in_range;
  logic [RAM_AW-1:0] m68_byte_addr;
  logic [7:0]        m68_byte_wdata;
  logic              unused_ok;

  assign hit_busreq     = (m68_addr[23:1] == BUSREQ_ADDR[23:1]);
  assign hit_reset      = (m68_addr[23:1] == RESET_ADDR[23:1]);
  assign hit_ram        = (m68_addr[23:RAM_AW] == RAM_BASE[23:RAM_AW]);
  assign m68_sel        = ~m68_as_n & (hit_busreq | hit_reset | hit_ram);
  // Odd byte only when LDS is the sole active strobe; word accesses use the even byte.
  assign a0             = m68_uds_n & ~m68_lds_n;
  assign m68_byte_addr  = {m68_addr[RAM_AW-1:1], a0};
  assign m68_byte_wdata = a0 ? m68_wdata[7:0] : m68_wdata[15:8];
  assign z80_in_range   = ({1'b0, z80_addr} < RAM_SIZE);
  assign unused_ok      = &{1'b0, m68_addr[0], z80_rd_n};

  // Handshake: the 68k holds AS low with stable address/data until DTACK goes
  // low; DTACK then stays low (data held) until AS is seen high again.
  always_comb begin
    state_d    = state_q;
    busreq_d   = busreq_q;
    zreset_d   = zreset_q;
    rdata_d    = rdata_q;
    m68_ram_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m68_sel) begin
          if (hit_ram && m68_rw && grant_q) begin
            state_d = S_RDWAIT;
          end else begin
            state_d = S_ACK;
            if (hit_busreq || hit_reset) begin
              if (m68_rw) begin
                rdata_d = hit_busreq ? {7'b0, ~grant_q, 8'h00} : 16'h0000;
              end else if (!m68_uds_n) begin
                if (hit_busreq) busreq_d = m68_wdata[8];
                else            zreset_d = m68_wdata[8];
              end
            end else if (m68_rw) begin
              rdata_d = 16'hFFFF;
            end else begin
              m68_ram_we = grant_q;
            end
          end
        end
      end
      S_RDWAIT: begin
        state_d = S_ACK;
        rdata_d = {ram_rdata, ram_rdata};
      end
      S_ACK: begin
        if (m68_as_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busreq_q <= 1'b0;
      zreset_q <= 1'b0;
      grant_q  <= 1'b0;
      rdata_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      busreq_q <= busreq_d;
      zreset_q <= zreset_d;
      grant_q  <= busreq_q & (~z80_busack_n | ~zreset_q);
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    ram_addr  = z80_addr[RAM_AW-1:0];
    ram_wdata = z80_wdata;
    ram_we    = ~z80_mreq_n & ~z80_wr_n & z80_in_range;
    z80_rdata = z80_in_range ? ram_rdata : 8'hFF;
    if (grant_q) begin
      ram_addr  = m68_byte_addr;
      ram_wdata = m68_byte_wdata;
      ram_we    = m68_ram_we;
      z80_rdata = 8'hFF;
    end
  end

  assign m68_rdata   = rdata_q;
  assign m68_dtack_n = (state_q != S_ACK);
  assign z80_busrq_n = ~busreq_q;
  assign z80_reset_n = zreset_q;
  assign dbg_state_o = state_q;
  assign dbg_grant_o = grant_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Bench for z80_bus_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model of registers, grant and RAM contents.
module tb_z80_bus_arbiter;

  localparam logic [23:0] BUSREQ_A = 24'hA11100;
  localparam logic [23:0] RESET_A  = 24'hA11200;
  localparam logic [23:0] RAM_B    = 24'hA00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] m68_addr;
  logic [15:0] m68_wdata, m68_rdata;
  logic        m68_as_n, m68_uds_n, m68_lds_n, m68_rw, m68_dtack_n;
  logic [15:0] z80_addr;
  logic [7:0]  z80_wdata, z80_rdata;
  logic        z80_mreq_n, z80_rd_n, z80_wr_n, z80_busack_n, z80_busrq_n, z80_reset_n;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_we;
  logic [1:0]  dbg_state_o;
  logic        dbg_grant_o;

  int n_cmp = 0;
  int n_fail = 0;

  logic        m_busreq, m_zreset;
  logic [7:0]  exp_mem [8192];
  logic [20:0] exp_q [$];

  logic [7:0] mem [8192];
  bit         mem_ready = 1'b0;

  z80_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m68_addr(m68_addr), .m68_wdata(m68_wdata), .m68_rdata(m68_rdata),
    .m68_as_n(m68_as_n), .m68_uds_n(m68_uds_n), .m68_lds_n(m68_lds_n),
    .m68_rw(m68_rw), .m68_dtack_n(m68_dtack_n),
    .z80_addr(z80_addr), .z80_wdata(z80_wdata), .z80_rdata(z80_rdata),
    .z80_mreq_n(z80_mreq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_busack_n(z80_busack_n), .z80_busrq_n(z80_busrq_n), .z80_reset_n(z80_reset_n),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .dbg_state_o(dbg_state_o), .dbg_grant_o(dbg_grant_o)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Synchronous single-port RAM, cleared on its first clock.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Scoreboard: every RAM write must match the next expected write.
  always begin
    @(negedge clk);
    #1;
    if (rst_n === 1'b1 && ram_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ram_write_unexpected: got addr %h data %h, required no write", ram_addr, ram_wdata);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({ram_addr, ram_wdata} !== e) begin
          n_fail++;
          $display("FAIL ram_write: got addr %h data %h, required addr %h data %h",
                   ram_addr, ram_wdata, e[20:8], e[7:0]);
        end
      end
    end
  end

  function automatic logic m_grant();
    return m_busreq & (~z80_busack_n | ~m_zreset);
  endfunction

  // ---- driver tasks ----
  task automatic m68_cycle(input logic [23:0] a, input logic rw, input logic uds_n,
                           input logic lds_n, input logic [15:0] wd,
                           output logic [15:0] rd, output int lat, output logic [3:1] gh,
                           output logic [3:1] rqh, output logic [12:0] ra0, output logic dt_rel);
    m68_addr = a; m68_rw = rw; m68_uds_n = uds_n; m68_lds_n = lds_n; m68_wdata = wd;
    m68_as_n = 1'b0;
    #1 ra0 = ram_addr;
    lat = 0;
    rd = 16'hxxxx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 3) begin gh[c] = dbg_grant_o; rqh[c] = z80_busrq_n; end
      if (lat == 0 && m68_dtack_n === 1'b0) begin lat = c; rd = m68_rdata; end
      if (lat != 0 && c >= 3) break;
    end
    m68_as_n = 1'b1; m68_uds_n = 1'b1; m68_lds_n = 1'b1;
    @(negedge clk);
    dt_rel = m68_dtack_n;
    repeat (2) @(negedge clk);
  endtask

  task automatic z80_write(input logic [15:0] a, input logic [7:0] d);
    z80_addr = a; z80_wdata = d; z80_mreq_n = 1'b0; z80_wr_n = 1'b0;
    @(negedge clk);
    z80_mreq_n = 1'b1; z80_wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic z80_read(input logic [15:0] a, output logic [7:0] d);
    z80_addr = a; z80_mreq_n = 1'b0; z80_rd_n = 1'b0;
    @(negedge clk);
    d = z80_rdata;
    z80_mreq_n = 1'b1; z80_rd_n = 1'b1;
    @(negedge clk);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    logic [15:0] rd; int lat; logic [3:1] gh, rqh; logic [12:0] ra; logic dtr;
    for (int i = 0; i < 8192; i++) exp_mem[i] = 8'h00;
    m_busreq = 1'b0; m_zreset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (m68_dtack_n !== 1'b1) begin n_fail++; $display("FAIL rst_dtack: got %b required 1", m68_dtack_n); end
    n_cmp++; if (z80_busrq_n !== 1'b1) begin n_fail++; $display("FAIL rst_busrq: got %b required 1", z80_busrq_n); end
    n_cmp++; if (z80_reset_n !== 1'b0) begin n_fail++; $display("FAIL rst_zreset: got %b required 0", z80_reset_n); end
    n_cmp++; if (m68_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h required 0000", m68_rdata); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b required 0", ram_we); end
    n_cmp++; if (dbg_grant_o !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %b required 0", dbg_grant_o); end
    n_cmp++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d required 0", dbg_state_o); end
    rst_n = 1'b1;
    @(negedge clk);
    m68_cycle(BUSREQ_A, 1'b1, 1'b0, 1'b0, 16'h0000, rd, lat, gh, rqh, ra, dtr);
    n_cmp++; if (rd !== 16'h0100) begin n_fail++; $display("FAIL rst_busreq_rd: got %h required 0100", rd); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL rst_busreq_lat: got %0d required 1", lat); end
    n_cmp++; if (dtr !== 1'b1) begin n_fail++; $display("FAIL rst_dtack_release: got %b required 1", dtr); end
  endtask

  task automatic test_busreq_grant();
    logic [15:0] rd; int lat; logic [3:1] gh, rqh; logic [12:0] ra; logic dtr;
    z80_busack_n = 1'b1;
    m68_cycle(BUSREQ_A, 1'b0, 1'b0, 1'b0, 16'h0100, rd, lat, gh, rqh, ra, dtr);
    m_busreq = 1'b1;
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL breq_wr_lat: got %0d required 1", lat); end
    n_cmp++; if (rqh[1] !== 1'b0) begin n_fail++; $display("FAIL breq_busrq_c1: got %b required 0", rqh[1]); end
    n_cmp++; if (gh !== 3'b110) begin n_fail++; $display("FAIL breq_grant_inreset: got %b required 110", gh); end
    m68_cycle(RESET_A, 1'b0, 1'b0, 1'b0, 16'h0100, rd, lat, gh, rqh, ra, dtr);
    m_zreset = 1'b1;
    n_cmp++; if (z80_reset_n !== 1'b1) begin n_fail++; $display("FAIL zrst_release: got %b required 1", z80_reset_n); end
    n_cmp++; if (gh[2] !== 1'b0) begin n_fail++; $display("FAIL grant_drop_running: got %b required 0", gh[2]); end
    repeat (3) @(negedge clk);
    z80_busack_n = 1'b0;
    #1;
    n_cmp++; if (dbg_grant_o !== 1'b0) begin n_fail++; $display("FAIL grant_early: got %b required 0", dbg_grant_o); end
    @(negedge clk);
    n_cmp++; if (dbg_grant_o !== 1'b1) begin n_fail++; $display("FAIL grant_rise: got %b required 1", dbg_grant_o); end
    m68_cycle(BUSREQ_A, 1'b1, 1'b0, 1'b0, 16'h0000, rd, lat, gh, rqh, ra, dtr);
    n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL breq_rd_granted: got %h required 0000", rd); end
    m68_cycle(BUSREQ_A, 1'b0, 1'b1, 1'b0, 16'h0000, rd, lat, gh, rqh, ra, dtr);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL lds_wr_lat: got %0d required 1", lat); end
    n_cmp++; if (z80_busrq_n !== 1'b0) begin n_fail++; $display("FAIL lds_wr_ignored: got %b required 0", z80_busrq_n); end
  endtask

  task automatic test_granted_ram();
    logic [15:0] rd; int lat; logic [3:1] gh, rqh; logic [12:0] ra; logic dtr;
    exp_q.push_back({13'h0003, 8'h5A}); exp_mem[3] = 8'h5A;
    m68_cycle(RAM_B | 24'h3, 1'b0, 1'b1, 1'b0, 16'h005A, rd, lat, gh, rqh, ra, dtr);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL gwr_lat: got %0d required 1", lat); end
    n_cmp++; if (ra !== 13'h0003) begin n_fail++; $display("FAIL gwr_addr: got %h required 0003", ra); end
    exp_q.push_back({13'h0002, 8'hA5}); exp_mem[2] = 8'hA5;
    m68_cycle(RAM_B | 24'h2, 1'b0, 1'b0, 1'b0, 16'hA5C3, rd, lat, gh, rqh, ra, dtr);
    exp_q.push_back({13'h0004, 8'h3C}); exp_mem[4] = 8'h3C;
    m68_cycle(RAM_B | 24'h4, 1'b0, 1'b0, 1'b1, 16'h3CFF, rd, lat, gh, rqh, ra, dtr);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL gwr_missing: got %0d pending required 0", exp_q.size()); end
    m68_cycle(RAM_B | 24'h2, 1'b1, 1'b0, 1'b0, 16'h0000, rd, lat, gh, rqh, ra, dtr);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL grd_lat: got %0d required 2", lat); end
    n_cmp++; if (ra !== 13'h0002) begin n_fail++; $display("FAIL grd_addr: got %h required 0002", ra); end
    n_cmp++; if (rd !== {exp_mem[2], exp_mem[2]}) begin n_fail++; $display("FAIL grd_data: got %h required %h", rd, {exp_mem[2], exp_mem[2]}); end
    m68_cycle(RAM_B | 24'h2, 1'b1, 1'b1, 1'b0, 16'h0000, rd, lat, gh, rqh, ra, dtr);
    n_cmp++; if (rd !== {exp_mem[3], exp_mem[3]}) begin n_fail++; $display("FAIL grd_odd: got %h required %h", rd, {exp_mem[3], exp_mem[3]}); end
  endtask

  task automatic test_ungranted();
    logic [15:0] rd; int lat; logic [3:1] gh, rqh; logic [12:0] ra; logic dtr;
    m68_cycle(BUSREQ_A, 1'b0, 1'b0, 1'b0, 16'h0000, rd, lat, gh, rqh, ra, dtr);
    m_busreq = 1'b0;
    n_cmp++; if (rqh[1] !== 1'b1) begin n_fail++; $display("FAIL rel_busrq: got %b required 1", rqh[1]); end
    n_cmp++; if (gh[2:1] !== 2'b01) begin n_fail++; $display("FAIL rel_grant_c2: got %b required 01", gh[2:1]); end
    m68_cycle(RAM_B | 24'h10, 1'b0, 1'b0, 1'b0, 16'h1234, rd, lat, gh, rqh, ra, dtr);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ugwr_lat: got %0d required 1", lat); end
    m68_cycle(RAM_B | 24'h10, 1'b1, 1'b0, 1'b0, 16'h0000, rd, lat, gh, rqh, ra, dtr);
    n_cmp++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL ugrd_data: got %h required FFFF", rd); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ugrd_lat: got %0d required 1", lat); end
    m68_cycle(BUSREQ_A, 1'b1, 1'b0, 1'b0, 16'h0000, rd, lat, gh, rqh, ra, dtr);
    n_cmp++; if (rd !== 16'h0100) begin n_fail++; $display("FAIL ug_busreq_rd: got %h required 0100", rd); end
  endtask

  task automatic test_z80();
    logic [7:0] d;
    n_cmp++; if (z80_reset_n !== 1'b1) begin n_fail++; $display("FAIL z80_running: got %b required 1", z80_reset_n); end
    exp_q.push_back({13'h1FFF, 8'hC3}); exp_mem[13'h1FFF] = 8'hC3;
    z80_write(16'h1FFF, 8'hC3);
    z80_read(16'h1FFF, d);
    n_cmp++; if (d !== 8'hC3) begin n_fail++; $display("FAIL z80_rd_1fff: got %h required C3", d); end
    z80_read(16'h4000, d);
    n_cmp++; if (d !== 8'hFF) begin n_fail++; $display("FAIL z80_rd_oor: got %h required FF", d); end
    z80_write(16'h4000, 8'h77);
    z80_read(16'h0000, d);
    n_cmp++; if (d !== exp_mem[0]) begin n_fail++; $display("FAIL z80_oor_alias: got %h required %h", d, exp_mem[0]); end
    z80_read(16'h0003, d);
    n_cmp++; if (d !== exp_mem[3]) begin n_fail++; $display("FAIL z80_rd_68kbyte: got %h required %h", d, exp_mem[3]); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL z80_wr_missing: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; int lat; logic [3:1] gh, rqh; logic [12:0] ra; logic dtr;
    m68_cycle(BUSREQ_A, 1'b0, 1'b0, 1'b0, 16'h0100, rd, lat, gh, rqh, ra, dtr);
    m_busreq = 1'b1;
    m68_addr = RAM_B | 24'h2; m68_rw = 1'b1; m68_uds_n = 1'b0; m68_lds_n = 1'b0; m68_as_n = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (m68_dtack_n === 1'b0) begin lat = c; break; end
    end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL mid_ack_reach: got %0d required 2", lat); end
    n_cmp++; if (m68_rdata !== {exp_mem[2], exp_mem[2]}) begin n_fail++; $display("FAIL mid_rdata: got %h required %h", m68_rdata, {exp_mem[2], exp_mem[2]}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (m68_dtack_n !== 1'b1) begin n_fail++; $display("FAIL mid_dtack: got %b required 1", m68_dtack_n); end
    n_cmp++; if (z80_busrq_n !== 1'b1) begin n_fail++; $display("FAIL mid_busrq: got %b required 1", z80_busrq_n); end
    n_cmp++; if (z80_reset_n !== 1'b0) begin n_fail++; $display("FAIL mid_zreset: got %b required 0", z80_reset_n); end
    n_cmp++; if (m68_rdata !== 16'h0000) begin n_fail++; $display("FAIL mid_rdata_clr: got %h required 0000", m68_rdata); end
    n_cmp++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL mid_state: got %0d required 0", dbg_state_o); end
    n_cmp++; if (dbg_grant_o !== 1'b0) begin n_fail++; $display("FAIL mid_grant: got %b required 0", dbg_grant_o); end
    m_busreq = 1'b0; m_zreset = 1'b0;
    m68_as_n = 1'b1; m68_uds_n = 1'b1; m68_lds_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] rd, wd, exp_rd, za; int lat, exp_lat, op, mode; logic [3:1] gh, rqh;
    logic [12:0] ra, byte_a; logic dtr, uds_n, lds_n, g, chk_rd; logic [23:0] a;
    logic [11:0] off; logic [7:0] zd, zexp;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        z80_busack_n = 1'($urandom_range(0, 1));
        repeat (2) @(negedge clk);
      end
      g = m_grant();
      op = $urandom_range(0, 10);
      wd = 16'($urandom);
      mode = $urandom_range(0, 2);
      uds_n = (mode == 2); lds_n = (mode == 1);
      off = 12'($urandom_range(0, 4095));
      a = RAM_B | {11'd0, off, 1'b0};
      byte_a = {off, (mode == 2)};
      chk_rd = 1'b0; exp_rd = 16'h0000; exp_lat = 1;
      case (op)
        0, 1: begin
          m68_cycle((op == 0) ? BUSREQ_A : RESET_A, 1'b0, uds_n, lds_n, wd, rd, lat, gh, rqh, ra, dtr);
          if (!uds_n) begin
            if (op == 0) m_busreq = wd[8];
            else         m_zreset = wd[8];
          end
        end
        2, 3: begin
          m68_cycle((op == 2) ? BUSREQ_A : RESET_A, 1'b1, uds_n, lds_n, 16'h0, rd, lat, gh, rqh, ra, dtr);
          chk_rd = 1'b1;
          exp_rd = (op == 2) ? {7'b0, ~g, 8'h00} : 16'h0000;
        end
        4, 5, 6: begin
          if (g) begin
            exp_mem[byte_a] = (mode == 2) ? wd[7:0] : wd[15:8];
            exp_q.push_back({byte_a, exp_mem[byte_a]});
          end
          m68_cycle(a, 1'b0, uds_n, lds_n, wd, rd, lat, gh, rqh, ra, dtr);
        end
        7, 8: begin
          m68_cycle(a, 1'b1, uds_n, lds_n, 16'h0, rd, lat, gh, rqh, ra, dtr);
          chk_rd = 1'b1;
          exp_rd = g ? {exp_mem[byte_a], exp_mem[byte_a]} : 16'hFFFF;
          exp_lat = g ? 2 : 1;
        end
        9: begin
          case ($urandom_range(0, 3))
            0: a = 24'hA11000;
            1: a = 24'hA12000;
            2: a = 24'h9FFFFE;
            default: a = 24'hA02000;
          endcase
          m68_cycle(a, 1'($urandom_range(0, 1)), uds_n, lds_n, wd, rd, lat, gh, rqh, ra, dtr);
          exp_lat = 0;
        end
        default: begin
          za = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 8191)) : 16'($urandom);
          zd = wd[7:0];
          if (mode == 0) begin
            if (!g && za < 16'd8192) begin
              exp_mem[za[12:0]] = zd;
              exp_q.push_back({za[12:0], zd});
            end
            z80_write(za, zd);
          end else begin
            zexp = (g || za >= 16'd8192) ? 8'hFF : exp_mem[za[12:0]];
            z80_read(za, zd);
            n_cmp++; if (zd !== zexp) begin n_fail++; $display("FAIL rnd_z80_rd[%0d]: addr %h got %h required %h", it, za, zd, zexp); end
          end
          lat = exp_lat;
        end
      endcase
      n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_lat[%0d]: op %0d got %0d required %0d", it, op, lat, exp_lat); end
      if (chk_rd) begin
        n_cmp++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: op %0d got %h required %h", it, op, rd, exp_rd); end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_wr_missing[%0d]: got %0d pending required 0", it, exp_q.size()); exp_q.delete(); end
      n_cmp++; if (z80_busrq_n !== ~m_busreq) begin n_fail++; $display("FAIL rnd_busrq[%0d]: got %b required %b", it, z80_busrq_n, ~m_busreq); end
      n_cmp++; if (z80_reset_n !== m_zreset) begin n_fail++; $display("FAIL rnd_zreset[%0d]: got %b required %b", it, z80_reset_n, m_zreset); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m68_addr = 24'h0; m68_wdata = 16'h0; m68_as_n = 1'b1; m68_uds_n = 1'b1; m68_lds_n = 1'b1; m68_rw = 1'b1;
    z80_addr = 16'h0; z80_wdata = 8'h0; z80_mreq_n = 1'b1; z80_rd_n = 1'b1; z80_wr_n = 1'b1;
    z80_busack_n = 1'b1;
    test_reset();
    test_busreq_grant();
    test_granted_ram();
    test_ungranted();
    test_z80();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
